// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the 5-stage MIPS pipeline.
// Holds the PC, chooses the next PC (sequential, branch or jump), runs a
// single-outstanding request/ready handshake to instruction memory and owns
// the IF/ID pipeline register under hazard-unit control.
//
// Ports:
//   clock, reset              clock (rising edge), async active-low reset
//   PCwrite, IFID_write       hazard unit: 0 = stall PC / hold IF/ID
//   IF_bubble                 hazard unit: flush IF/ID, redirect to branch
//   PCSrc, branch_target      taken-branch redirect and its target
//   jump, jump_target         jump redirect and its target
//   imem_req, imem_addr       fetch request and address (held while waiting)
//   imem_ready, imem_rdata    fetch response and instruction word
//   IFID_instr, IFID_PC_Plus4, IFID_valid   IF/ID register contents
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        PCwrite,
  input  logic        IFID_write,
  input  logic        IF_bubble,
  input  logic        PCSrc,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IFID_instr,
  output logic [31:0] IFID_PC_Plus4,
  output logic        IFID_valid
);

  typedef enum logic {FETCH, DISCARD} state_t;

  state_t      state, state_nxt;
  logic        req_q;
  logic [31:0] pc, pc_nxt;
  logic [31:0] stale_addr, stale_nxt;
  logic [31:0] instr_q, instr_nxt;
  logic [31:0] pc4_q, pc4_nxt;
  logic        valid_q, valid_nxt;

  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic        redirect;
  logic        fire;
  logic        waiting;

  assign pc_plus4 = pc + 32'd4;
  assign redirect = PCSrc | IF_bubble | jump;
  // Branch is the older instruction, so it outranks a jump in ID.
  assign target   = ((PCSrc | IF_bubble) ? branch_target : jump_target) & ~32'h3;
  assign fire     = req_q & imem_ready;
  assign waiting  = req_q & ~imem_ready;

  // While discarding, the memory still expects the address it was given.
  assign imem_req      = req_q;
  assign imem_addr     = (state == DISCARD) ? stale_addr : pc;
  assign IFID_instr    = instr_q;
  assign IFID_PC_Plus4 = pc4_q;
  assign IFID_valid    = valid_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= FETCH;
      req_q      <= 1'b0;
      pc         <= RESET_PC;
      stale_addr <= RESET_PC;
      instr_q    <= NOP_INSTR;
      pc4_q      <= '0;
      valid_q    <= 1'b0;
    end else begin
      state      <= state_nxt;
      req_q      <= 1'b1;
      pc         <= pc_nxt;
      stale_addr <= stale_nxt;
      instr_q    <= instr_nxt;
      pc4_q      <= pc4_nxt;
      valid_q    <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    stale_nxt = stale_addr;
    instr_nxt = instr_q;
    pc4_nxt   = pc4_q;
    valid_nxt = valid_q;

    case (state)
      FETCH: begin
        if (redirect) begin
          pc_nxt    = target;
          instr_nxt = NOP_INSTR;
          pc4_nxt   = '0;
          valid_nxt = 1'b0;
          if (waiting) begin
            state_nxt = DISCARD;
            stale_nxt = pc;
          end
        end else if (fire) begin
          // PCwrite=0 drops the response; the same PC is re-requested.
          if (PCwrite) begin
            pc_nxt = pc_plus4;
            if (IFID_write) begin
              instr_nxt = imem_rdata;
              pc4_nxt   = pc_plus4;
              valid_nxt = 1'b1;
            end
          end
        end else if (IFID_write) begin
          instr_nxt = NOP_INSTR;
          pc4_nxt   = '0;
          valid_nxt = 1'b0;
        end
      end

      DISCARD: begin
        if (redirect) begin
          pc_nxt    = target;
          instr_nxt = NOP_INSTR;
          pc4_nxt   = '0;
          valid_nxt = 1'b0;
        end else if (IFID_write) begin
          instr_nxt = NOP_INSTR;
          pc4_nxt   = '0;
          valid_nxt = 1'b0;
        end
        if (imem_ready) begin
          state_nxt = FETCH;
        end
      end

      default: state_nxt = FETCH;
    endcase
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        PCwrite, IFID_write, IF_bubble, PCSrc, jump;
  logic [31:0] branch_target, jump_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] IFID_instr, IFID_PC_Plus4;
  logic        IFID_valid;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clock = ~clock;

  // Instruction memory contents are a fixed function of the address.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  assign imem_rdata = mem(imem_addr);

  fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0000)) dut (
    .clock(clock), .reset(reset),
    .PCwrite(PCwrite), .IFID_write(IFID_write), .IF_bubble(IF_bubble),
    .PCSrc(PCSrc), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .IFID_instr(IFID_instr), .IFID_PC_Plus4(IFID_PC_Plus4),
    .IFID_valid(IFID_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] instr,
                          input logic [31:0] pc4, input logic valid);
    chk({tag, "_instr"}, IFID_instr, instr);
    chk({tag, "_pc4"}, IFID_PC_Plus4, pc4);
    chk({tag, "_valid"}, {31'd0, IFID_valid}, {31'd0, valid});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    PCwrite = 1'b1; IFID_write = 1'b1; IF_bubble = 1'b0; PCSrc = 1'b0;
    jump = 1'b0; branch_target = '0; jump_target = '0; imem_ready = 1'b1;
    #1;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk_ifid("rst", 32'h0, 32'h0, 1'b0);
    #1 reset = 1'b1;

    tick;
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    chk("first_valid", {31'd0, IFID_valid}, 32'd0);
    tick; chk_ifid("seq0", mem(32'h0), 32'h4, 1'b1);
    tick; chk_ifid("seq4", mem(32'h4), 32'h8, 1'b1);
    tick; chk_ifid("seq8", mem(32'h8), 32'hC, 1'b1);
    tick; chk_ifid("seqC", mem(32'hC), 32'h10, 1'b1);
    chk("pc10", imem_addr, 32'h10);

    // Load-use stall at PC=0x10.
    PCwrite = 1'b0; IFID_write = 1'b0;
    tick;
    chk("stall_addr", imem_addr, 32'h10);
    chk_ifid("stall_hold", mem(32'hC), 32'h10, 1'b1);
    PCwrite = 1'b1; IFID_write = 1'b1;
    tick;
    chk_ifid("resume", mem(32'h10), 32'h14, 1'b1);
    chk("resume_addr", imem_addr, 32'h14);
    tick; tick; tick;
    chk("pc20", imem_addr, 32'h20);

    // Taken branch at PC=0x20.
    PCSrc = 1'b1; IF_bubble = 1'b1; branch_target = 32'h40;
    tick;
    chk_ifid("br_flush", 32'h0, 32'h0, 1'b0);
    chk("br_addr", imem_addr, 32'h40);
    PCSrc = 1'b0; IF_bubble = 1'b0;
    tick;
    chk_ifid("br_tgt", mem(32'h40), 32'h44, 1'b1);

    // Jump during a 3-cycle memory wait.
    imem_ready = 1'b0; jump = 1'b1; jump_target = 32'h80;
    tick;
    chk("dis_addr0", imem_addr, 32'h44);
    chk("dis_req0", {31'd0, imem_req}, 32'd1);
    chk("dis_valid0", {31'd0, IFID_valid}, 32'd0);
    jump = 1'b0;
    tick; chk("dis_addr1", imem_addr, 32'h44);
    tick; chk("dis_addr2", imem_addr, 32'h44);
    imem_ready = 1'b1;
    tick;
    chk("dis_done_addr", imem_addr, 32'h80);
    chk("dis_dropped", {31'd0, IFID_valid}, 32'd0);
    tick;
    chk_ifid("jmp_tgt", mem(32'h80), 32'h84, 1'b1);

    // Branch outranks jump; low target bits are cleared.
    PCSrc = 1'b1; branch_target = 32'h103; jump = 1'b1; jump_target = 32'h200;
    tick;
    chk("prio_addr", imem_addr, 32'h100);
    PCSrc = 1'b0; jump = 1'b0;
    tick;
    chk_ifid("prio_tgt", mem(32'h100), 32'h104, 1'b1);

    // PC wrap-around.
    jump = 1'b1; jump_target = 32'hFFFF_FFFC;
    tick;
    chk("wrap_pre", imem_addr, 32'hFFFF_FFFC);
    jump = 1'b0;
    tick;
    chk_ifid("wrap", mem(32'hFFFF_FFFC), 32'h0, 1'b1);
    chk("wrap_addr", imem_addr, 32'h0);

    // Redirect wins over a stall.
    PCwrite = 1'b0; PCSrc = 1'b1; branch_target = 32'h60;
    tick;
    chk("rd_stall_addr", imem_addr, 32'h60);
    chk("rd_stall_valid", {31'd0, IFID_valid}, 32'd0);
    PCwrite = 1'b1; PCSrc = 1'b0;

    // Asynchronous reset while discarding.
    imem_ready = 1'b0; jump = 1'b1; jump_target = 32'h300;
    tick;
    chk("pre_rst_addr", imem_addr, 32'h60);
    jump = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("arst_req", {31'd0, imem_req}, 32'd0);
    chk("arst_addr", imem_addr, 32'h0);
    chk_ifid("arst", 32'h0, 32'h0, 1'b0);
    #1 reset = 1'b1; imem_ready = 1'b1;
    tick;
    chk("post_rst_req", {31'd0, imem_req}, 32'd1);
    chk("post_rst_addr", imem_addr, 32'h0);
    tick;
    chk_ifid("post_rst", mem(32'h0), 32'h4, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
